// File: rtl/cs_arb_pkg.sv
// cs_arb_pkg: shared constants, state type and helper for cs_arbiter.
// Used by cs_arbiter_if, rr_pick and cs_arbiter via import cs_arb_pkg::*.
package cs_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    // 74x138 enables {G2B, G2A, G1}: only G1 high enables the decoder.
    localparam logic [2:0] G_ENABLE  = 3'b001;
    localparam logic [2:0] G_DISABLE = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GUARD
    } cs_state_t;

    // Decoder output pattern for a given select.
    function automatic logic [NUM_REQ-1:0] sel_onehot(
        input logic [SEL_W-1:0] sel
    );
        return NUM_REQ'(1) << sel;
    endfunction

endpackage

// File: rtl/cs_arbiter_if.sv
// cs_arbiter_if: requester-side bus of the chip-select arbiter.
// Ports: req (requests), s/g (decoder select/enables), gnt, busy, timeout.
// master = requester side (drives req), slave = arbiter side.
interface cs_arbiter_if;
    import cs_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [SEL_W-1:0]   s;
    logic [2:0]         g;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic               timeout;

    modport master (
        output req,
        input  s,
        input  g,
        input  gnt,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output s,
        output g,
        output gnt,
        output busy,
        output timeout
    );

endinterface

// File: rtl/cs_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker for cs_arbiter.
// Ports: req/last in; idx = first set req after last (mod 8), any = |req.
module rr_pick
    import cs_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;
    logic             found;

    // Candidates last+1 .. last+8; the 3-bit add wraps, so the
    // previous owner is tried last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + SEL_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cs_arbiter.sv
// cs_arbiter: round-robin owner of a shared 74x138 chip-select decoder.
// Ports: clk, rst (async, active high), bus (cs_arbiter_if.slave).
// Params: GUARD_CYC guard cycles (1..15), MAX_HOLD grant limit (2..255).
// Optional preemption enabled by defining CS_ARB_TIMEOUT_EN.
module cs_arbiter
    import cs_arb_pkg::*;
#(
    parameter int GUARD_CYC = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic         clk,
    input  logic         rst,
    cs_arbiter_if.slave  bus
);

    cs_state_t          state_q;
    logic [SEL_W-1:0]   s_q;
    logic [2:0]         g_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               busy_q;
    logic               to_q;
    logic [SEL_W-1:0]   last_q;
    logic [3:0]         gcnt_q;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               preempt;

    rr_pick u_pick (
        .req  (bus.req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef CS_ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       others;

    // Any request other than the owner's; gnt_q is one-hot in GRANT.
    assign others  = |(bus.req & ~gnt_q);
    assign preempt = (hold_q == 8'(MAX_HOLD - 1)) && others;

    // Zero outside GRANT, so every entry into GRANT starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (state_q != GRANT) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + 8'd1;
        end
    end
`else
    localparam int unused_max_hold = MAX_HOLD;

    assign preempt = 1'b0;
`endif

    // GUARD lasts GUARD_CYC guard cycles plus one arbitration cycle,
    // so the decoder stays off for GUARD_CYC+1 cycles between owners.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            g_q     <= G_DISABLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            last_q  <= 3'd7;
            gcnt_q  <= '0;
        end else begin
            to_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= GRANT;
                        s_q     <= pick_idx;
                        g_q     <= G_ENABLE;
                        gnt_q   <= sel_onehot(pick_idx);
                        busy_q  <= 1'b1;
                        last_q  <= pick_idx;
                    end
                end
                GRANT: begin
                    if (!bus.req[s_q] || preempt) begin
                        state_q <= GUARD;
                        g_q     <= G_DISABLE;
                        gnt_q   <= '0;
                        gcnt_q  <= '0;
                        to_q    <= bus.req[s_q];
                    end
                end
                GUARD: begin
                    if (gcnt_q == 4'(GUARD_CYC)) begin
                        if (pick_any) begin
                            state_q <= GRANT;
                            s_q     <= pick_idx;
                            g_q     <= G_ENABLE;
                            gnt_q   <= sel_onehot(pick_idx);
                            last_q  <= pick_idx;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.s       = s_q;
    assign bus.g       = g_q;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = to_q;

endmodule

// File: tb/tb_cs_arbiter.sv
// tb_cs_arbiter: scoreboard bench for cs_arbiter (GUARD_CYC=1, MAX_HOLD=16).
// Expected grants are queued by the stimulus and checked by a monitor.
module tb_cs_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cs_arbiter_if bus ();

    cs_arbiter #(
        .GUARD_CYC (1),
        .MAX_HOLD  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int idx;
        int gap;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   to_cnt   = 0;
    int   gap_cnt  = 0;
    logic [2:0] prev_g = 3'b000;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // gap = number of g=000 cycles expected before this grant; 0 = skip.
    task automatic push_exp(int idx, int gap);
        exp_t e;
        e.idx = idx;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic wait_grant();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.g == 3'b001) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL grant_wait: got no grant in 64 cycles, expected one");
        end else begin
            check("busy_in_grant", 32'(bus.busy), 32'd1);
        end
    endtask

    // Called on the first grant cycle; owner holds for 'cycles' cycles.
    task automatic hold_release(int cycles, bit reraise, bit clear_all);
        logic [2:0] cur;
        cur = bus.s;
        repeat (cycles - 1) @(negedge clk);
        if (clear_all) bus.req = '0;
        else bus.req[cur] = 1'b0;
        @(negedge clk);
        if (reraise) bus.req[cur] = 1'b1;
    endtask

    // Monitor: pops one expectation per new grant, checks invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_g  = 3'b000;
                gap_cnt = 0;
            end else begin
                check("gnt_vs_sel", 32'(bus.gnt),
                      (bus.g == 3'b001) ? (32'd1 << bus.s) : 32'd0);
                if (bus.timeout) begin
                    to_cnt++;
                    check("timeout_g_off", 32'(bus.g), 32'd0);
                end
                if (bus.g == 3'b001 && prev_g != 3'b001) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant: got s=%0d, expected none",
                                 bus.s);
                    end else begin
                        mon_e = q.pop_front();
                        check("grant_idx", 32'(bus.s), 32'(mon_e.idx));
                        if (mon_e.gap > 0)
                            check("guard_gap", 32'(gap_cnt), 32'(mon_e.gap));
                    end
                    gap_cnt = 0;
                end else if (bus.g == 3'b000) begin
                    gap_cnt++;
                end
                prev_g = bus.g;
            end
        end
    end

    initial begin
        int  n;
        bit  held;

        // Reset held with all requests pending.
        rst     = 1'b1;
        bus.req = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_g", 32'(bus.g), 32'd0);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);

        // Full rotation 0..7,0 with 3-cycle holds.
        push_exp(0, 0);
        for (int i = 1; i < 8; i++) push_exp(i, 2);
        push_exp(0, 2);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wait_grant();
            hold_release(3, i < 8, i == 8);
        end
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // last=0: 7 wins before wrapping to 0.
        bus.req = 8'b1000_0001;
        push_exp(7, 0);
        push_exp(0, 2);
        wait_grant();
        hold_release(2, 1'b0, 1'b0);
        wait_grant();
        hold_release(2, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Single requester re-wins after each guard gap.
        bus.req = 8'h10;
        push_exp(4, 0);
        push_exp(4, 2);
        push_exp(4, 2);
        for (int i = 0; i < 3; i++) begin
            wait_grant();
            hold_release(2, i < 2, i == 2);
        end
        repeat (3) @(negedge clk);

`ifdef CS_ARB_TIMEOUT_EN
        // Owner 2 preempted by 4 after 16 grant cycles.
        bus.req = 8'h04;
        push_exp(2, 0);
        push_exp(4, 2);
        push_exp(2, 2);
        wait_grant();
        bus.req[4] = 1'b1;
        n = 1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.g != 3'b001) break;
            n++;
        end
        check("hold_len", 32'(n), 32'd16);
        check("timeout_pulse", 32'(bus.timeout), 32'd1);
        wait_grant();
        hold_release(2, 1'b0, 1'b0);
        wait_grant();
        hold_release(2, 1'b0, 1'b1);
`else
        // Owner 3 keeps the bus while 5 waits.
        bus.req = 8'h08;
        push_exp(3, 0);
        push_exp(5, 2);
        wait_grant();
        bus.req[5] = 1'b1;
        held = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bus.s != 3'd3 || bus.g != 3'b001) held = 1'b0;
        end
        check("hold_no_preempt", 32'(held), 32'd1);
        hold_release(1, 1'b0, 1'b0);
        wait_grant();
        hold_release(2, 1'b0, 1'b1);
`endif
        repeat (3) @(negedge clk);

        // One-cycle request pulse gets a one-cycle grant.
        push_exp(6, 0);
        bus.req = 8'h40;
        @(negedge clk);
        bus.req = 8'h00;
        check("pulse_g_on", 32'(bus.g), 32'd1);
        check("pulse_s", 32'(bus.s), 32'd6);
        @(negedge clk);
        check("pulse_g_off", 32'(bus.g), 32'd0);
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of a grant to 5.
        bus.req = 8'h20;
        push_exp(5, 0);
        wait_grant();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_g", 32'(bus.g), 32'd0);
        check("arst_gnt", 32'(bus.gnt), 32'd0);
        check("arst_s", 32'(bus.s), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        bus.req = 8'h21;
        @(negedge clk);
        @(negedge clk);
        push_exp(0, 0);
        rst = 1'b0;
        wait_grant();
        hold_release(2, 1'b0, 1'b1);
        repeat (5) @(negedge clk);

        check("queue_empty", 32'(q.size()), 32'd0);
`ifdef CS_ARB_TIMEOUT_EN
        check("timeout_count", 32'(to_cnt), 32'd1);
`else
        check("timeout_count", 32'(to_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
